vc_input_buffer: RTL
====================

# vc_input_buffer

Ingress stage of the PCIe QoS module. Accepts the transaction stream (`Push_fifos`, `VC_ID`, `DataWord`) and steers each word into one of four per-virtual-channel FIFOs. It tracks each FIFO's occupancy against percentage thresholds and returns per-VC `Pause_stb`, `Continue_stb` and `Error_full` to the transaction source. Each VC exposes its head word show-ahead to the downstream arbiter, which drains it with per-VC pops.

## Interface

- `DATA_W`, 4: transaction word width.
- `DEPTH`, 8: entries per VC FIFO; power of 2, ≥4.
- `PCT_W`, 7: threshold width, in percent of `DEPTH`.

Ports, clock and reset first:

- `CLK`  in  1  single clock; all logic on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Set_init`  in  1  1 = configuration mode; thresholds are latched.
- `Th_H`  in  PCT_W  pause threshold, percent.
- `Th_L`  in  PCT_W  continue threshold, percent.
- `Push_fifos`  in  1  write `DataWord` into the FIFO selected by `VC_ID`.
- `VC_ID`  in  2  target VC.
- `DataWord`  in  DATA_W  write data.
- `Pop_vc`  in  4  per-VC pop from the downstream arbiter.
- `Head_data`  out  4*DATA_W  head word of each VC; VC v occupies bits [v*DATA_W +: DATA_W].
- `Empty_vc`  out  4  per-VC empty flag.
- `Pause_stb`  out  4  one-cycle pulse: VC reached the high threshold.
- `Continue_stb`  out  4  one-cycle pulse: paused VC drained to the low threshold.
- `Error_full`  out  4  one-cycle pulse: push to a full VC was dropped.
- `Idle`  out  1  all four FIFOs are empty.

## Operation

- **States.** `INIT` and `RUN`.
  - `Reset` → `INIT`.
  - `INIT` with `Set_init`=0 → `RUN` at the next edge.
  - `RUN` with `Set_init`=1 → `INIT` at the next edge; all FIFOs are flushed and the paused flags are cleared.
- **Thresholds.** `Th_H` and `Th_L` are registered every cycle while in `INIT` and frozen in `RUN`.
  - Inputs above 100 are clamped to 100.
  - `hi_cnt = ceil(Th_H*DEPTH/100)`, `lo_cnt = floor(Th_L*DEPTH/100)`. Use integer arithmetic with width ≥ PCT_W + log2(DEPTH) + 1.
  - With DEPTH=8, Th_H=75 and Th_L=25 give hi_cnt=6, lo_cnt=2.
- **Pushes and pops.** Both are ignored in `INIT`.
  - Push to a full VC: the word is dropped and `Error_full[v]` pulses.
  - Pop of an empty VC: ignored, no error.
  - Simultaneous push and pop on the same VC: both take effect and the count is unchanged. This includes a full VC, where the push is accepted and no error is raised.
- **Pause/continue.** Each VC keeps a `paused` flag; `next_cnt` is the count after the current push/pop.
  - `Pause_stb[v]` pulses when `next_cnt >= hi_cnt` while `cnt < hi_cnt`, and sets `paused`.
  - `Continue_stb[v]` pulses when `paused` and `next_cnt <= lo_cnt`, and clears `paused`.
  - The two strobes are never high together for the same VC.
- **Ordering.** FIFO order is preserved per VC. There is no ordering between VCs.
- **Reset values.** All outputs are 0 except `Empty_vc`=4'hF and `Idle`=1. `Head_data` reads 0 while empty.

## Timing

- Push at edge N: at edge N the word is visible on `Head_data`, `Empty_vc[v]` falls, and the count updates (first-word fall-through).
- `Pause_stb`, `Continue_stb` and `Error_full` are registered. They are asserted for exactly one cycle, starting at the same edge that updates the count.
- A pop at edge N presents the next word at edge N.
- `Idle` is registered and reflects the post-edge counts.
- `Reset` dominates `Set_init` and all traffic in the same cycle.
- A reset mid-stream discards all contents without emitting strobes.
- The `INIT`→`RUN` transition edge accepts no push; the first push is accepted at the following edge.

## Structure

- Shared package `qos_pkg` holds:
  - `NUM_VC`=4;
  - the state enum `{INIT, RUN}`;
  - the constant 100 used as the percent base;
  - the per-VC strobe vector typedef.
- One sub-module, `vc_fifo`, instantiated 4 times:
  - contains the DEPTH×DATA_W first-word fall-through array, read/write pointers and count (log2(DEPTH)+1 bits);
  - has push/pop/flush inputs and data/empty/full/count outputs.
- The top level holds the FSM, threshold latch and math, VC demux, paused flags and strobe registers.

## Test plan

1. **Pause.** Reset, `Set_init`=1 with Th_H=75 and Th_L=25, then release. Push 6 words to VC0 → `Pause_stb[0]` pulses once, on the 6th push edge. No strobe fires on the other VCs.
2. **Continue.** From the end of scenario 1, pop VC0 four times → no strobe at counts 5 and 4. `Continue_stb[0]` pulses once at count 2. Popped data is 0,1,2,3 in order.
3. **Overflow.** Fill VC1 with words 0..7, then push 9 → `Error_full[1]` pulses one cycle. The count stays 8 and the head is still 0.
4. **Push and pop at full.** With VC1 full, push 12 and pop VC1 in the same cycle → no error, count stays 8. The head becomes 1 and the last word read out is 12.
5. **Interleaved traffic.** Push the sequence (VC,data) = (0,0) (0,1) (0,2) (1,3) (1,4) (2,5) (2,6) (3,7) (2,8) → each VC drains in order: VC0=0,1,2; VC1=3,4; VC2=5,6,8; VC3=7. `Idle`=1 after the final pop.
6. **Mid-run re-init.** With 5 words in VC2, assert `Set_init`=1 → next edge: all FIFOs empty, `Idle`=1, no strobes. Pushes during `INIT` are ignored. New thresholds Th_H=50 and Th_L=0 give a pause at count 4.

Source files
------------

// File: rtl/qos_pkg.sv
// Shared definitions for the PCIe QoS ingress path.
package qos_pkg;
  localparam int NUM_VC   = 4;
  localparam int PCT_BASE = 100;

  typedef enum logic {INIT, RUN} state_t;

  typedef logic [NUM_VC-1:0] vc_vec_t;
endpackage

// File: rtl/vc_input_buffer_if.sv
// Transaction-source / arbiter side bundle of the VC input buffer.
interface vc_input_buffer_if #(
  parameter int DATA_W = 4,
  parameter int PCT_W  = 7
);
  import qos_pkg::*;

  logic                     Set_init;
  logic [PCT_W-1:0]         Th_H;
  logic [PCT_W-1:0]         Th_L;
  logic                     Push_fifos;
  logic [1:0]               VC_ID;
  logic [DATA_W-1:0]        DataWord;
  vc_vec_t                  Pop_vc;
  logic [NUM_VC*DATA_W-1:0] Head_data;
  vc_vec_t                  Empty_vc;
  vc_vec_t                  Pause_stb;
  vc_vec_t                  Continue_stb;
  vc_vec_t                  Error_full;
  logic                     Idle;

  modport master (
    output Set_init, Th_H, Th_L, Push_fifos, VC_ID, DataWord, Pop_vc,
    input  Head_data, Empty_vc, Pause_stb, Continue_stb, Error_full, Idle
  );

  modport slave (
    input  Set_init, Th_H, Th_L, Push_fifos, VC_ID, DataWord, Pop_vc,
    output Head_data, Empty_vc, Pause_stb, Continue_stb, Error_full, Idle
  );
endinterface

// File: rtl/vc_fifo.sv
// Per-VC first-word fall-through FIFO with flush and occupancy count.
module vc_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  localparam int LOG_D = $clog2(DEPTH),
  localparam int CNT_W = LOG_D + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] data,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [LOG_D-1:0]             wr_ptr, rd_ptr;
  logic                         push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign data    = empty ? '0 : mem[rd_ptr];

  // storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok && !flush && !rst) mem[wr_ptr] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + LOG_D'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + LOG_D'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end
endmodule

// File: rtl/vc_input_buffer.sv
// Ingress stage: steers words into four VC FIFOs and flags pause/continue/overflow.
module vc_input_buffer
  import qos_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  parameter int PCT_W  = 7
) (
  input  logic            CLK,
  input  logic            Reset,
  vc_input_buffer_if.slave bus
);
  localparam int LOG_D  = $clog2(DEPTH);
  localparam int CNT_W  = LOG_D + 1;
  localparam int MATH_W = PCT_W + LOG_D + 1;

  state_t                           state;
  logic [CNT_W-1:0]                 hi_cnt, lo_cnt, hi_calc, lo_calc;
  logic [PCT_W-1:0]                 th_h_c, th_l_c;
  logic [MATH_W-1:0]                hi_prod, lo_prod;
  logic                             active, flush, idle_nx;
  vc_vec_t                          push_v, pop_v, push_ok, pop_ok;
  vc_vec_t                          empty, full, paused;
  vc_vec_t                          pause_nx, cont_nx, err_nx;
  logic [NUM_VC-1:0][CNT_W-1:0]     cnt, next_cnt;
  logic [NUM_VC-1:0][DATA_W-1:0]    head;

  // traffic only flows in RUN; a Set_init in RUN flushes instead
  assign active = (state == RUN) && !bus.Set_init;
  assign flush  = (state == RUN) && bus.Set_init;

  // clamp to 100 %, then hi rounds up and lo rounds down
  assign th_h_c  = (bus.Th_H > PCT_W'(PCT_BASE)) ? PCT_W'(PCT_BASE) : bus.Th_H;
  assign th_l_c  = (bus.Th_L > PCT_W'(PCT_BASE)) ? PCT_W'(PCT_BASE) : bus.Th_L;
  assign hi_prod = MATH_W'(th_h_c) * MATH_W'(DEPTH) + MATH_W'(PCT_BASE - 1);
  assign lo_prod = MATH_W'(th_l_c) * MATH_W'(DEPTH);
  assign hi_calc = CNT_W'(hi_prod / MATH_W'(PCT_BASE));
  assign lo_calc = CNT_W'(lo_prod / MATH_W'(PCT_BASE));

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (CLK),
      .rst   (Reset),
      .flush (flush),
      .push  (push_v[v]),
      .pop   (pop_v[v]),
      .din   (bus.DataWord),
      .data  (head[v]),
      .empty (empty[v]),
      .full  (full[v]),
      .count (cnt[v])
    );
  end

  assign bus.Head_data = head;
  assign bus.Empty_vc  = empty;

  // per-VC demux, post-edge count and strobe conditions
  always_comb begin
    push_v   = '0;
    pop_v    = '0;
    push_ok  = '0;
    pop_ok   = '0;
    pause_nx = '0;
    cont_nx  = '0;
    err_nx   = '0;
    next_cnt = cnt;
    idle_nx  = 1'b1;
    for (int v = 0; v < NUM_VC; v++) begin
      push_v[v]   = active && bus.Push_fifos && (bus.VC_ID == 2'(v));
      pop_v[v]    = active && bus.Pop_vc[v];
      pop_ok[v]   = pop_v[v] && !empty[v];
      push_ok[v]  = push_v[v] && (!full[v] || pop_ok[v]);
      err_nx[v]   = push_v[v] && full[v] && !pop_ok[v];
      next_cnt[v] = cnt[v] + CNT_W'(push_ok[v]) - CNT_W'(pop_ok[v]);
      pause_nx[v] = (next_cnt[v] >= hi_cnt) && (cnt[v] < hi_cnt);
      // continue only on a net drain, and never alongside a pause
      cont_nx[v]  = paused[v] && pop_ok[v] && !push_ok[v] &&
                    (next_cnt[v] <= lo_cnt) && !pause_nx[v];
      if (next_cnt[v] != '0) idle_nx = 1'b0;
    end
  end

  // mode FSM, threshold latch, paused flags and registered strobes
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state            <= INIT;
      hi_cnt           <= '0;
      lo_cnt           <= '0;
      paused           <= '0;
      bus.Pause_stb    <= '0;
      bus.Continue_stb <= '0;
      bus.Error_full   <= '0;
      bus.Idle         <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          hi_cnt <= hi_calc;
          lo_cnt <= lo_calc;
          if (!bus.Set_init) state <= RUN;
        end
        RUN: if (bus.Set_init) state <= INIT;
      endcase
      paused           <= flush ? '0 : ((paused | pause_nx) & ~cont_nx);
      bus.Pause_stb    <= pause_nx;
      bus.Continue_stb <= cont_nx;
      bus.Error_full   <= err_nx;
      bus.Idle         <= flush ? 1'b1 : idle_nx;
    end
  end
endmodule
